// File: rtl/partition_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : partition_pkg
//  Purpose  : Shared types and helpers for the partition-module table scheduler
//             (FSM states, table entry, popcount / highest-set-bit / bit-length).
//  Revision : 1.0 - initial release
// ============================================================================
package partition_pkg;

    localparam int MAX_MASK_W = 64;
    localparam int MAX_ID_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_FIN    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // One table entry; narrower masks/ids are stored zero-extended.
    typedef struct packed {
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_MASK_W-1:0] mask;
    } entry_t;

    function automatic logic [6:0] popcount(input logic [MAX_MASK_W-1:0] m);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < MAX_MASK_W; i++) begin
            c = c + 7'(m[i]);
        end
        return c;
    endfunction

    // Returns 0 for an all-zero mask as well as for a mask whose top bit is bit 0.
    function automatic logic [5:0] highest_set_bit(input logic [MAX_MASK_W-1:0] m);
        logic [5:0] h;
        h = '0;
        for (int i = 0; i < MAX_MASK_W; i++) begin
            if (m[i]) begin
                h = 6'(i);
            end
        end
        return h;
    endfunction

    // Number of bits needed to represent v (0 for v == 0).
    function automatic logic [6:0] bit_length(input logic [5:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) begin
                n = 7'(i + 1);
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker: one-hot grant to the first
//             asserted request at or after the pointer, wrapping modulo NREQ.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         grant_o
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the requesters starting at the pointer and take the first one asserted.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/partition_table_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : partition_table_scheduler
//  Purpose  : Owns the partition-module table, arbitrates PNEW requests,
//             deduplicates by sequential scan, allocates modules, accumulates
//             discovery cost and, on finalize, the MDL execution cost.
//  Revision : 1.0 - initial release
// ============================================================================
module partition_table_scheduler
    import partition_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MAX_MODULES = 64,
    parameter int MASK_W      = 64,
    parameter int ID_W        = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*MASK_W-1:0]         req_mask,
    output logic [NREQ-1:0]                req_ready,
    output logic                           rsp_valid,
    output logic [$clog2(NREQ)-1:0]        rsp_req,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           rsp_hit,
    output logic                           rsp_full,
    input  logic                           fin_valid,
    output logic                           fin_ready,
    output logic                           done,
    output logic [$clog2(MAX_MODULES):0]   num_modules,
    output logic [63:0]                    mu_discovery,
    output logic [63:0]                    mu_execution,
    output logic [63:0]                    mu_total
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_MODULES) + 1;
    localparam int AW    = CNT_W - 1;

    state_e              state_q, state_d;
    logic                accept_req, accept_fin;
    logic [NREQ-1:0]     grant;
    logic [PTR_W-1:0]    grant_idx, rr_ptr_q, req_idx_q;
    logic [MASK_W-1:0]   mask_q;
    logic [CNT_W-1:0]    scan_q, num_q;
    logic                hit_q, scan_end, scan_hit;
    entry_t              tbl_q [MAX_MODULES];
    logic                tbl_we;
    logic [ID_W-1:0]     next_id_q;
    logic                cur_vld_q;
    logic [AW-1:0]       cur_idx_q;
    logic [MAX_MASK_W-1:0] fin_mask;
    logic [6:0]          fin_pop, fin_bl;
    logic [5:0]          fin_hsb;
    logic [63:0]         fin_cost, exec_add;
    logic [NREQ-1:0]     req_ready_q;
    logic                rsp_valid_q, rsp_hit_q, rsp_full_q, fin_ready_q, done_q;
    logic [PTR_W-1:0]    rsp_req_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [63:0]         disc_q, exec_q, total_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    // One-hot grant to binary requester index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    // Single compare port: the entry under the scan counter against the latched mask.
    assign scan_end = (scan_q == num_q);
    assign scan_hit = !scan_end && (tbl_q[scan_q[AW-1:0]].mask == MAX_MASK_W'(mask_q));
    assign tbl_we   = (state_q == ST_COMMIT) && !hit_q && (num_q < CNT_W'(MAX_MODULES));

    // MDL execution cost of the current module.
    always_comb begin
        fin_mask = tbl_q[cur_idx_q].mask;
        fin_pop  = popcount(fin_mask);
        fin_hsb  = highest_set_bit(fin_mask);
        fin_bl   = (fin_hsb == 6'd0) ? 7'd1 : bit_length(fin_hsb);
        fin_cost = (fin_pop != 7'd0) ? (64'(fin_bl) * 64'(fin_pop)) : 64'd1;
        exec_add = cur_vld_q ? fin_cost : 64'd0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; finalize wins over PNEW in IDLE, nothing is accepted elsewhere.
    always_comb begin
        state_d    = state_q;
        accept_req = 1'b0;
        accept_fin = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fin_valid) begin
                    accept_fin = 1'b1;
                    state_d    = ST_FIN;
                end else if (|req_valid) begin
                    accept_req = 1'b1;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN:   if (scan_hit || scan_end) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            ST_FIN:    state_d = ST_DONE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Table storage: one write port used when a miss allocates a new entry.
    for (genvar e = 0; e < MAX_MODULES; e++) begin : g_tbl
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tbl_q[e] <= '0;
            end else if (tbl_we && (num_q[AW-1:0] == AW'(e))) begin
                tbl_q[e] <= '{id: MAX_ID_W'(next_id_q), mask: MAX_MASK_W'(mask_q)};
            end
        end
    end

    // Datapath: grant latch, scan counter, commit bookkeeping, cost accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            req_idx_q   <= '0;
            mask_q      <= '0;
            scan_q      <= '0;
            hit_q       <= 1'b0;
            num_q       <= '0;
            next_id_q   <= '0;
            cur_vld_q   <= 1'b0;
            cur_idx_q   <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_req_q   <= '0;
            rsp_id_q    <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_full_q  <= 1'b0;
            fin_ready_q <= 1'b0;
            done_q      <= 1'b0;
            disc_q      <= '0;
            exec_q      <= '0;
            total_q     <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            fin_ready_q <= accept_fin;
            if (accept_req) begin
                req_ready_q <= grant;
                req_idx_q   <= grant_idx;
                mask_q      <= req_mask[grant_idx*MASK_W +: MASK_W];
                rr_ptr_q    <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                scan_q      <= '0;
                hit_q       <= 1'b0;
            end
            if (state_q == ST_SCAN) begin
                if (scan_hit)       hit_q  <= 1'b1;
                else if (!scan_end) scan_q <= scan_q + 1'b1;
            end
            if (state_q == ST_COMMIT) begin
                disc_q      <= disc_q + 64'(popcount(MAX_MASK_W'(mask_q)));
                rsp_valid_q <= 1'b1;
                rsp_req_q   <= req_idx_q;
                rsp_hit_q   <= hit_q;
                rsp_full_q  <= 1'b0;
                if (hit_q) begin
                    cur_vld_q <= 1'b1;
                    cur_idx_q <= scan_q[AW-1:0];
                    rsp_id_q  <= tbl_q[scan_q[AW-1:0]].id[ID_W-1:0];
                end else if (tbl_we) begin
                    cur_vld_q <= 1'b1;
                    cur_idx_q <= num_q[AW-1:0];
                    rsp_id_q  <= next_id_q;
                    next_id_q <= next_id_q + 1'b1;
                    num_q     <= num_q + 1'b1;
                end else begin
                    rsp_id_q   <= '0;
                    rsp_full_q <= 1'b1;
                end
            end
            if (state_q == ST_FIN) begin
                exec_q  <= exec_q + exec_add;
                total_q <= disc_q + exec_q + exec_add;
                done_q  <= 1'b1;
            end
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_req      = rsp_req_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_full     = rsp_full_q;
    assign fin_ready    = fin_ready_q;
    assign done         = done_q;
    assign num_modules  = num_q;
    assign mu_discovery = disc_q;
    assign mu_execution = exec_q;
    assign mu_total     = total_q;

endmodule
`default_nettype wire
